// File: rtl/opl2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : opl2_pkg
// Description : Shared OPL2 types and constants used by the host write path.
// Revision    : 1.0 - initial release
// ============================================================================
package opl2_pkg;

    typedef struct packed {
        logic       valid;
        logic [7:0] address;
        logic [7:0] data;
    } opl2_reg_wr_t;

    localparam int HOST_FIFO_DEPTH    = 4;
    localparam int HOST_WR_GAP_CYCLES = 8;

    localparam logic [4:0] OPL2_STATUS_LOW_BITS = 5'b00110;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GAP  = 1'b1
    } host_if_state_t;

endpackage
`default_nettype wire

// File: rtl/opl2_host_fifo.sv
`default_nettype none
// ============================================================================
// Module      : opl2_host_fifo
// Description : Synchronous FIFO of pending {address, data} register writes.
// Revision    : 1.0 - initial release
// ============================================================================
module opl2_host_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             ic_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             empty_next
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    // A push on a full FIFO is legal when the same cycle frees a slot.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    assign empty_next = (cnt_d == '0);

    always_ff @(posedge clk) begin
        if (!ic_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/opl2_host_if.sv
`default_nettype none
// ============================================================================
// Module      : opl2_host_if
// Description : OPL2 host port front end: address latch, paced register-write
//               emitter and status read. Define OPL2_HOST_FIFO_EN for a
//               FIFO_DEPTH-entry write buffer; otherwise a single holding
//               register is used.
// Revision    : 1.0 - initial release
// ============================================================================
module opl2_host_if
    import opl2_pkg::*;
#(
    parameter int FIFO_DEPTH    = HOST_FIFO_DEPTH,
    parameter int WR_GAP_CYCLES = HOST_WR_GAP_CYCLES
) (
    input  logic         clk,
    input  logic         ic_n,
    input  logic         host_wr,
    input  logic         host_rd,
    input  logic         host_a0,
    input  logic [7:0]   host_din,
    output logic [7:0]   host_dout,
    input  logic         ft1,
    input  logic         ft2,
    output opl2_reg_wr_t reg_wr,
    output logic         busy,
    output logic         overflow
);

    localparam int              GAP_W    = (WR_GAP_CYCLES > 1) ? $clog2(WR_GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(WR_GAP_CYCLES - 1);

    host_if_state_t   state_q, state_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    opl2_reg_wr_t     reg_wr_q, reg_wr_d;
    logic [7:0]       host_dout_q, host_dout_d;
    logic [7:0]       addr_latch_q, addr_latch_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;

    logic             wr_addr, wr_data;
    logic             push, pop;
    logic             store_full, store_empty, store_empty_next;
    logic [15:0]      store_din, store_dout;

    assign wr_addr   = host_wr & ~host_a0;
    assign wr_data   = host_wr &  host_a0;
    assign store_din = {addr_latch_q, host_din};
    assign pop       = (state_q == IDLE) & (gap_cnt_q == '0) & ~store_empty;
    assign push      = wr_data & (~store_full | pop);

`ifdef OPL2_HOST_FIFO_EN
    opl2_host_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk        (clk),
        .ic_n       (ic_n),
        .push       (push),
        .pop        (pop),
        .din        (store_din),
        .dout       (store_dout),
        .full       (store_full),
        .empty      (store_empty),
        .empty_next (store_empty_next)
    );
`else
    logic        hold_valid_q, hold_valid_d;
    logic [15:0] hold_data_q, hold_data_d;

    // FIFO_DEPTH has no effect on the single holding register.
    if (FIFO_DEPTH < 1) begin : g_depth_ignored
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (pop) begin
            hold_valid_d = 1'b0;
        end
        if (push) begin
            hold_valid_d = 1'b1;
            hold_data_d  = store_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!ic_n) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end

    assign store_full       = hold_valid_q;
    assign store_empty      = ~hold_valid_q;
    assign store_empty_next = ~hold_valid_d;
    assign store_dout       = hold_data_q;
`endif

    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        reg_wr_d     = '0;
        host_dout_d  = host_dout_q;
        addr_latch_d = addr_latch_q;
        overflow_d   = overflow_q | (wr_data & store_full & ~pop);

        if (wr_addr) begin
            addr_latch_d = host_din;
        end

        if (host_rd) begin
            host_dout_d = host_a0 ? 8'hFF : {ft1 | ft2, ft1, ft2, OPL2_STATUS_LOW_BITS};
        end

        if (pop) begin
            reg_wr_d  = {1'b1, store_dout};
            gap_cnt_d = GAP_LOAD;
            state_d   = (WR_GAP_CYCLES > 1) ? GAP : IDLE;
        end else if (state_q == GAP) begin
            // Counter reaches zero on the same edge the emitter re-enters IDLE.
            if (gap_cnt_q <= GAP_W'(1)) begin
                gap_cnt_d = '0;
                state_d   = IDLE;
            end else begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
        end

        busy_d = ~store_empty_next | (state_d == GAP);
    end

    always_ff @(posedge clk) begin
        if (!ic_n) begin
            state_q      <= IDLE;
            gap_cnt_q    <= '0;
            reg_wr_q     <= '0;
            host_dout_q  <= 8'h00;
            addr_latch_q <= 8'h00;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            reg_wr_q     <= reg_wr_d;
            host_dout_q  <= host_dout_d;
            addr_latch_q <= addr_latch_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
        end
    end

    assign reg_wr    = reg_wr_q;
    assign host_dout = host_dout_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_opl2_host_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_opl2_host_if
// Description : Directed self-checking bench for opl2_host_if (both store
//               builds, selected by OPL2_HOST_FIFO_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_opl2_host_if;
    import opl2_pkg::*;

`ifdef OPL2_HOST_FIFO_EN
    localparam int BURST3_N  = 3;
    localparam bit BURST3_OV = 1'b0;
    localparam int LONG_N    = 5;
    localparam bit FIVE_OV   = 1'b0;
`else
    localparam int BURST3_N  = 2;
    localparam bit BURST3_OV = 1'b1;
    localparam int LONG_N    = 2;
    localparam bit FIVE_OV   = 1'b1;
`endif

    logic         clk = 1'b0;
    logic         ic_n = 1'b0;
    logic         host_wr = 1'b0;
    logic         host_rd = 1'b0;
    logic         host_a0 = 1'b0;
    logic [7:0]   host_din = 8'h00;
    logic [7:0]   host_dout;
    logic         ft1 = 1'b0;
    logic         ft2 = 1'b0;
    opl2_reg_wr_t reg_wr;
    logic         busy;
    logic         overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [15:0] pq[$];
    int          pc[$];

    opl2_host_if dut (
        .clk       (clk),
        .ic_n      (ic_n),
        .host_wr   (host_wr),
        .host_rd   (host_rd),
        .host_a0   (host_a0),
        .host_din  (host_din),
        .host_dout (host_dout),
        .ft1       (ft1),
        .ft2       (ft2),
        .reg_wr    (reg_wr),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse recorder: every valid cycle with its address/data and cycle stamp.
    always @(negedge clk) begin
        if (reg_wr.valid) begin
            pq.push_back({reg_wr.address, reg_wr.data});
            pc.push_back(cyc);
        end
    end

    task automatic step(input logic wr, input logic rd, input logic a0, input logic [7:0] din);
        host_wr = wr; host_rd = rd; host_a0 = a0; host_din = din;
        @(negedge clk);
        host_wr = 1'b0; host_rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy && i < 300) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL wait_idle busy=%b required 0 after %0d cycles", busy, i); end
    endtask

    task automatic do_reset();
        ic_n = 1'b0;
        idle(2);
        ic_n = 1'b1;
        pq.delete(); pc.delete();
    endtask

    task automatic test_reset();
        ic_n = 1'b0; host_wr = 1'b1; host_a0 = 1'b1; host_din = 8'h99; host_rd = 1'b1;
        idle(2);
        host_wr = 1'b0; host_rd = 1'b0;
        checks++; if (reg_wr !== 17'h0) begin failures++; $display("FAIL reset_reg_wr got=%h required=0", reg_wr); end
        checks++; if (host_dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h required=00", host_dout); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", busy); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b required=0", overflow); end
        ic_n = 1'b1;
        pq.delete(); pc.delete();
        idle(3);
        checks++; if (pq.size() != 0) begin failures++; $display("FAIL reset_priority pulses=%0d required=0", pq.size()); end
    endtask

    task automatic test_single_write();
        wait_idle();
        pq.delete(); pc.delete();
        step(1, 0, 0, 8'h20);
        step(1, 0, 1, 8'h41);
        checks++; if (reg_wr.valid !== 1'b0) begin failures++; $display("FAIL single_early valid=%b required=0", reg_wr.valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_push got=%b required=1", busy); end
        idle(1);
        checks++; if (reg_wr !== {1'b1, 8'h20, 8'h41}) begin failures++; $display("FAIL single_pulse got=%h required=12041", reg_wr); end
        idle(1);
        checks++; if (reg_wr !== 17'h0) begin failures++; $display("FAIL single_after got=%h required=0", reg_wr); end
        idle(5);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_gap got=%b required=1", busy); end
        idle(1);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_drop got=%b required=0", busy); end
        checks++; if (pq.size() != 1) begin failures++; $display("FAIL single_count pulses=%0d required=1", pq.size()); end
    endtask

    task automatic test_burst();
        logic [7:0] bd [3];
        bd = '{8'h11, 8'h22, 8'h33};
        do_reset();
        step(1, 0, 0, 8'hB0);
        for (int i = 0; i < 3; i++) step(1, 0, 1, bd[i]);
        idle(30);
        wait_idle();
        checks++; if (overflow !== BURST3_OV) begin failures++; $display("FAIL burst_overflow got=%b required=%b", overflow, BURST3_OV); end
        checks++; if (pq.size() != BURST3_N) begin failures++; $display("FAIL burst_count pulses=%0d required=%0d", pq.size(), BURST3_N); end
        for (int i = 0; i < BURST3_N && i < pq.size(); i++) begin
            checks++; if (pq[i] !== {8'hB0, bd[i]}) begin failures++; $display("FAIL burst_data[%0d] got=%h required=%h", i, pq[i], {8'hB0, bd[i]}); end
            if (i > 0) begin
                checks++; if (pc[i] - pc[i-1] != 8) begin failures++; $display("FAIL burst_gap[%0d] got=%0d required=8", i, pc[i] - pc[i-1]); end
            end
        end
    endtask

    task automatic test_capacity(input int nwr, input bit exp_ov);
        int exp_n;
        exp_n = (nwr < LONG_N) ? nwr : LONG_N;
        do_reset();
        step(1, 0, 0, 8'h40);
        for (int i = 0; i < nwr; i++) step(1, 0, 1, 8'(i + 1));
        idle(60);
        wait_idle();
        checks++; if (overflow !== exp_ov) begin failures++; $display("FAIL cap%0d_overflow got=%b required=%b", nwr, overflow, exp_ov); end
        checks++; if (pq.size() != exp_n) begin failures++; $display("FAIL cap%0d_count pulses=%0d required=%0d", nwr, pq.size(), exp_n); end
        for (int i = 0; i < exp_n && i < pq.size(); i++) begin
            checks++; if (pq[i] !== {8'h40, 8'(i + 1)}) begin failures++; $display("FAIL cap%0d_data[%0d] got=%h required=%h", nwr, i, pq[i], {8'h40, 8'(i + 1)}); end
        end
        pq.delete(); pc.delete();
        step(1, 0, 1, 8'h09);
        idle(2);
        checks++; if (pq.size() != 1 || pq[0] !== 16'h4009) begin failures++; $display("FAIL cap%0d_refill pulses=%0d required one 4009", nwr, pq.size()); end
        checks++; if (overflow !== exp_ov) begin failures++; $display("FAIL cap%0d_sticky got=%b required=%b", nwr, overflow, exp_ov); end
    endtask

    task automatic test_status_read();
        ft1 = 1'b1; ft2 = 1'b0;
        step(0, 1, 0, 8'h00);
        checks++; if (host_dout !== 8'hC6) begin failures++; $display("FAIL status_ft1 got=%h required=C6", host_dout); end
        ft1 = 1'b0;
        idle(2);
        checks++; if (host_dout !== 8'hC6) begin failures++; $display("FAIL status_hold got=%h required=C6", host_dout); end
        step(0, 1, 0, 8'h00);
        checks++; if (host_dout !== 8'h06) begin failures++; $display("FAIL status_none got=%h required=06", host_dout); end
        ft2 = 1'b1;
        step(0, 1, 0, 8'h00);
        checks++; if (host_dout !== 8'hA6) begin failures++; $display("FAIL status_ft2 got=%h required=A6", host_dout); end
        ft1 = 1'b1;
        step(0, 1, 0, 8'h00);
        checks++; if (host_dout !== 8'hE6) begin failures++; $display("FAIL status_both got=%h required=E6", host_dout); end
        step(0, 1, 1, 8'h00);
        checks++; if (host_dout !== 8'hFF) begin failures++; $display("FAIL status_dataport got=%h required=FF", host_dout); end
        ft1 = 1'b0; ft2 = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        ft1 = 1'b1;
        step(0, 1, 0, 8'h00);
        ft1 = 1'b0;
        step(1, 0, 0, 8'h55);
        for (int i = 1; i <= 3; i++) step(1, 0, 1, 8'(i));
        idle(2);
        checks++; if (busy !== 1'b1 || pq.size() != 1) begin failures++; $display("FAIL midrst_pre busy=%b pulses=%0d required busy=1 pulses=1", busy, pq.size()); end
        ic_n = 1'b0;
        idle(1);
        checks++; if (reg_wr !== 17'h0) begin failures++; $display("FAIL midrst_reg_wr got=%h required=0", reg_wr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b required=0", busy); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL midrst_overflow got=%b required=0", overflow); end
        checks++; if (host_dout !== 8'h00) begin failures++; $display("FAIL midrst_dout got=%h required=00", host_dout); end
        ic_n = 1'b1;
        pq.delete(); pc.delete();
        idle(30);
        checks++; if (pq.size() != 0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_drain pulses=%0d busy=%b required 0/0", pq.size(), busy); end
        step(1, 0, 1, 8'h77);
        idle(1);
        checks++; if (reg_wr !== {1'b1, 8'h00, 8'h77}) begin failures++; $display("FAIL midrst_addr_clear got=%h required=10077", reg_wr); end
    endtask

    task automatic test_simultaneous();
        wait_idle();
        ft1 = 1'b0; ft2 = 1'b1;
        step(1, 1, 0, 8'h30);
        checks++; if (host_dout !== 8'hA6) begin failures++; $display("FAIL simul_status got=%h required=A6", host_dout); end
        step(1, 1, 1, 8'h5A);
        checks++; if (host_dout !== 8'hFF) begin failures++; $display("FAIL simul_dataread got=%h required=FF", host_dout); end
        idle(1);
        checks++; if (reg_wr !== {1'b1, 8'h30, 8'h5A}) begin failures++; $display("FAIL simul_write got=%h required=1305A", reg_wr); end
        ft2 = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_write();
        test_burst();
        test_capacity(5, FIVE_OV);
        test_capacity(8, 1'b1);
        test_status_read();
        test_reset_mid_op();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
